// File: rtl/sensor_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sensor_scan_ctrl
// Description : Sequential three-channel sensor scanner with mux settling,
//               atomic result update and debounced CO / water alarms.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_scan_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PERSIST       = 3,
  parameter int MQ_LIMIT      = 1,
  parameter int WATER_LIMIT   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic [3:0] mq7in,
  input  logic [3:0] waterLevel,
  input  logic       tempin,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] mq_val,
  output logic [3:0] water_val,
  output logic       temp_val,
  output logic       scan_done,
  output logic       mqled,
  output logic       waterled
);

  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] c_persist     = 3'(PERSIST);
  localparam logic [3:0] c_mq_limit    = 4'(MQ_LIMIT);
  localparam logic [3:0] c_water_limit = 4'(WATER_LIMIT);
  localparam logic [1:0] c_ch_last     = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ch;
  logic [1:0] w_ch_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_capture;
  logic       w_commit;

  logic [3:0] r_mq_sh;
  logic [3:0] r_water_sh;
  logic       r_temp_sh;
  logic [2:0] r_mq_cnt;
  logic [2:0] r_w_cnt;
  logic [2:0] w_mq_cnt_nxt;
  logic [2:0] w_w_cnt_nxt;
  logic       w_mq_hit;
  logic       w_w_hit;

  // --------------------------------------------------------------------------
  // Sequencer state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ch    <= 2'd0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_commit    = 1'b0;
    sel         = 2'd0;
    busy        = 1'b1;

    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = SETTLE;
          w_ch_nxt    = 2'd0;
          w_cnt_nxt   = 4'd0;
        end
      end

      SETTLE: begin
        sel = r_ch;
        if (abort) begin
          w_state_nxt = IDLE;
          w_ch_nxt    = 2'd0;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == c_settle_last) begin
          w_state_nxt = CAPTURE;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end

      CAPTURE: begin
        sel = r_ch;
        if (abort) begin
          w_state_nxt = IDLE;
          w_ch_nxt    = 2'd0;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_capture = 1'b1;
          w_cnt_nxt = 4'd0;
          if (r_ch == c_ch_last) begin
            w_state_nxt = DONE;
            w_ch_nxt    = 2'd0;
          end else begin
            w_state_nxt = SETTLE;
            w_ch_nxt    = r_ch + 2'd1;
          end
        end
      end

      DONE: begin
        w_ch_nxt  = 2'd0;
        w_cnt_nxt = 4'd0;
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_commit    = 1'b1;
          w_state_nxt = cont ? SETTLE : IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_ch_nxt    = 2'd0;
        w_cnt_nxt   = 4'd0;
        busy        = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-channel shadow registers, loaded only on a channel's capture edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mq_sh    <= 4'd0;
      r_water_sh <= 4'd0;
      r_temp_sh  <= 1'b0;
    end else if (w_capture) begin
      case (r_ch)
        2'd0:    r_mq_sh    <= mq7in;
        2'd1:    r_water_sh <= waterLevel;
        default: r_temp_sh  <= tempin;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Alarm persistence: saturate at PERSIST while exceeding, clear otherwise
  // --------------------------------------------------------------------------
  always_comb begin
    w_mq_hit     = (r_mq_sh >= c_mq_limit);
    w_w_hit      = (r_water_sh > c_water_limit);
    w_mq_cnt_nxt = 3'd0;
    w_w_cnt_nxt  = 3'd0;
    if (w_mq_hit) begin
      w_mq_cnt_nxt = (r_mq_cnt >= c_persist) ? c_persist : r_mq_cnt + 3'd1;
    end
    if (w_w_hit) begin
      w_w_cnt_nxt = (r_w_cnt >= c_persist) ? c_persist : r_w_cnt + 3'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Published results: all values and alarms move together at DONE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq_val    <= 4'd0;
      water_val <= 4'd0;
      temp_val  <= 1'b0;
      r_mq_cnt  <= 3'd0;
      r_w_cnt   <= 3'd0;
      mqled     <= 1'b0;
      waterled  <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= w_commit;
      if (w_commit) begin
        mq_val    <= r_mq_sh;
        water_val <= r_water_sh;
        temp_val  <= r_temp_sh;
        r_mq_cnt  <= w_mq_cnt_nxt;
        r_w_cnt   <= w_w_cnt_nxt;
        mqled     <= (w_mq_cnt_nxt == c_persist);
        waterled  <= (w_w_cnt_nxt == c_persist);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sensor_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_scan_ctrl
// Description : Self-checking bench for sensor_scan_ctrl, scan-position model
//               plus directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_scan_ctrl;

  localparam int S    = 4;
  localparam int P    = 3;
  localparam int MQL  = 1;
  localparam int WL   = 5;
  localparam int SCAN = 3 * (S + 1) + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] mq7in = 4'd0;
  logic [3:0] waterLevel = 4'd0;
  logic       tempin = 1'b0;
  logic [1:0] sel;
  logic       busy;
  logic [3:0] mq_val;
  logic [3:0] water_val;
  logic       temp_val;
  logic       scan_done;
  logic       mqled;
  logic       waterled;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  sensor_scan_ctrl #(
    .SETTLE_CYCLES(S),
    .PERSIST      (P),
    .MQ_LIMIT     (MQL),
    .WATER_LIMIT  (WL)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cont      (cont),
    .abort     (abort),
    .mq7in     (mq7in),
    .waterLevel(waterLevel),
    .tempin    (tempin),
    .sel       (sel),
    .busy      (busy),
    .mq_val    (mq_val),
    .water_val (water_val),
    .temp_val  (temp_val),
    .scan_done (scan_done),
    .mqled     (mqled),
    .waterled  (waterled)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [31:0] outs();
    return {17'd0, sel, busy, mq_val, water_val, temp_val, scan_done, mqled, waterled};
  endfunction

  // Reference: a scan is a position 1..SCAN counted from the start edge.
  // Channel c is captured on the edge that closes position (c+1)*(S+1);
  // results commit on the edge that closes position SCAN.
  logic       m_busy = 1'b0;
  int         m_pos = 0;
  logic [3:0] cap_mq = 4'd0, cap_w = 4'd0;
  logic       cap_t = 1'b0;
  logic [3:0] m_mq = 4'd0, m_w = 4'd0;
  logic       m_t = 1'b0, m_done = 1'b0, m_mqled = 1'b0, m_wled = 1'b0;
  int         m_mqc = 0, m_wc = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_pos = 0; cap_mq = 4'd0; cap_w = 4'd0; cap_t = 1'b0;
      m_mq = 4'd0; m_w = 4'd0; m_t = 1'b0; m_done = 1'b0;
      m_mqled = 1'b0; m_wled = 1'b0; m_mqc = 0; m_wc = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin m_busy = 1'b1; m_pos = 1; end
      end else if (abort) begin
        m_busy = 1'b0; m_pos = 0;
      end else if (m_pos == SCAN) begin
        m_mq = cap_mq; m_w = cap_w; m_t = cap_t; m_done = 1'b1;
        m_mqc = (int'(cap_mq) >= MQL) ? ((m_mqc < P) ? m_mqc + 1 : P) : 0;
        m_wc  = (int'(cap_w)  >  WL)  ? ((m_wc  < P) ? m_wc  + 1 : P) : 0;
        m_mqled = (m_mqc == P);
        m_wled  = (m_wc == P);
        if (cont) m_pos = 1;
        else begin m_busy = 1'b0; m_pos = 0; end
      end else begin
        if (m_pos == S + 1)           cap_mq = mq7in;
        else if (m_pos == 2 * (S + 1)) cap_w = waterLevel;
        else if (m_pos == 3 * (S + 1)) cap_t = tempin;
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] esel;
    if (rst_n) begin
      esel = (m_busy && m_pos <= 3 * (S + 1)) ? 2'((m_pos - 1) / (S + 1)) : 2'd0;
      check("cycle_model", outs(),
            {17'd0, esel, m_busy, m_mq, m_w, m_t, m_done, m_mqled, m_wled});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; cont = 1'b0; abort = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_done && n < 100);
    if (!scan_done) check("scan_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sel(input logic [1:0] v);
    int n = 0;
    while (sel != v && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sel != v) check("sel_timeout", 32'(sel), 32'(v));
  endtask

  task automatic run_scan(input logic [3:0] mq, input logic [3:0] w, input logic t, output int lat);
    mq7in = mq; waterLevel = w; tempin = t;
    start_pulse();
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int seen;

    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;

    // Single scan latency and values
    run_scan(4'd2, 4'd7, 1'b1, lat);
    check("first_latency", 32'(lat), 32'd16);
    check("first_values", {23'd0, mq_val, water_val, temp_val}, {23'd0, 4'd2, 4'd7, 1'b1});
    check("first_leds", {30'd0, mqled, waterled}, 32'd0);

    // Continuous mode: CO alarm after third exceeding scan
    do_reset();
    mq7in = 4'd3; waterLevel = 4'd0; tempin = 1'b0; cont = 1'b1;
    start_pulse();
    for (int k = 1; k <= 3; k++) begin
      wait_done(lat);
      check("cont_period", 32'(lat), 32'd16);
      check("cont_mqled", 32'(mqled), (k == 3) ? 32'd1 : 32'd0);
    end
    mq7in = 4'd0;
    wait_done(lat);
    check("mqled_clear", 32'(mqled), 32'd0);
    cont = 1'b0;
    wait_done(lat);

    // Water threshold is strict, and persistence must be consecutive
    do_reset();
    for (int k = 0; k < 3; k++) begin
      run_scan(4'd0, 4'd5, 1'b0, lat);
      check("water5_led", 32'(waterled), 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      run_scan(4'd0, 4'd6, 1'b0, lat);
      check("water6_led", 32'(waterled), (k == 2) ? 32'd1 : 32'd0);
    end
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_scan(4'd0, (k == 2) ? 4'd5 : 4'd6, 1'b0, lat);
      check("water6656_led", 32'(waterled), 32'd0);
    end

    // Inputs changed after their channel's capture are not seen
    do_reset();
    mq7in = 4'd4; waterLevel = 4'd8; tempin = 1'b0;
    start_pulse();
    wait_sel(2'd1);
    mq7in = 4'd9; tempin = 1'b1;
    wait_sel(2'd2);
    waterLevel = 4'd1;
    wait_done(lat);
    check("capture_window", {23'd0, mq_val, water_val, temp_val}, {23'd0, 4'd4, 4'd8, 1'b1});

    // Start while busy ignored, abort keeps previous results
    do_reset();
    mq7in = 4'd3; waterLevel = 4'd2; tempin = 1'b0;
    start_pulse();
    repeat (3) @(negedge clk);
    start_pulse();
    wait_done(lat);
    check("busy_start_ignored", 32'(lat), 32'd12);
    mq7in = 4'd9; waterLevel = 4'd9; tempin = 1'b1;
    start_pulse();
    wait_sel(2'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (scan_done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_values", {23'd0, mq_val, water_val, temp_val}, {23'd0, 4'd3, 4'd2, 1'b0});

    // Asynchronous reset in the final capture cycle with an active alarm
    do_reset();
    for (int k = 0; k < 3; k++) run_scan(4'd5, 4'd0, 1'b0, lat);
    check("pre_reset_mqled", 32'(mqled), 32'd1);
    start_pulse();
    wait_sel(2'd2);
    repeat (S) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(4'd1, 4'd1, 1'b1, lat);
    check("post_reset_latency", 32'(lat), 32'd16);
    check("post_reset_values", {23'd0, mq_val, water_val, temp_val}, {23'd0, 4'd1, 4'd1, 1'b1});

    // Randomized traffic, checked every cycle by the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start      = ($urandom_range(0, 3) == 0);
      cont       = ($urandom_range(0, 2) == 0);
      abort      = ($urandom_range(0, 63) == 0);
      mq7in      = 4'($urandom_range(0, 3));
      waterLevel = 4'($urandom_range(4, 8));
      tempin     = 1'($urandom);
    end
    start = 1'b0; cont = 1'b0; abort = 1'b0;
    repeat (2 * SCAN) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sensor_scan_ctrl.md
SENSOR_SCAN_CTRL -- requirements
Module: sensor_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, cycles the analog mux is held on a channel before capture (legal 1..15).
REQ-002 SHALL have parameter PERSIST, default 3, consecutive exceeding scans needed to raise an alarm (legal 1..7).
REQ-003 SHALL have parameter MQ_LIMIT, default 1, CO alarm when mq value >= MQ_LIMIT.
REQ-004 SHALL have parameter WATER_LIMIT, default 5, water alarm when water value > WATER_LIMIT.
REQ-005 SHALL have ports, one clock and reset asynchronous active-low:
  clk  input  1  system clock, all state on rising edge
  rst_n  input  1  asynchronous active-low reset
  start  input  1  request one scan; sampled only in IDLE
  cont  input  1  1 = begin a new scan immediately after each scan
  abort  input  1  synchronous abort of a scan in progress
  mq7in  input  4  CO sensor reading, valid after settling
  waterLevel  input  4  water level reading, valid after settling
  tempin  input  1  temperature comparator bit
  sel  output  2  mux channel select: 0 = mq7, 1 = water, 2 = temp
  busy  output  1  high in every state except IDLE
  mq_val  output  4  last complete-scan CO value
  water_val  output  4  last complete-scan water value
  temp_val  output  1  last complete-scan temperature bit
  scan_done  output  1  one-cycle pulse, new values and alarms valid
  mqled  output  1  debounced CO alarm
  waterled  output  1  debounced water alarm

Function
REQ-006 SHALL implement FSM states IDLE, SETTLE, CAPTURE, DONE with 2-bit channel index ch (0..2).
REQ-007 IDLE: start=1 -> SETTLE, ch=0, settle counter cleared; start=0 -> stay.
REQ-008 SETTLE: sel=ch; counter increments each cycle; after exactly SETTLE_CYCLES cycles in SETTLE -> CAPTURE.
REQ-009 CAPTURE (1 cycle): shadow register of channel ch loads mq7in / waterLevel / tempin at the closing edge; ch<2 -> ch+1, SETTLE, counter cleared; ch=2 -> DONE.
REQ-010 DONE (1 cycle): on the closing edge, shadow values transfer to mq_val/water_val/temp_val together, alarm counters update, scan_done registers to 1; then cont=1 -> SETTLE with ch=0, cont=0 -> IDLE.
REQ-011 scan_done SHALL be high exactly one cycle, in the cycle after DONE, coincident with the new outputs and alarms.
REQ-012 Latency: scan_done high after edge N+3*(SETTLE_CYCLES+1)+1 when start is sampled at edge N (16 edges at default); continuous-mode period = 3*(SETTLE_CYCLES+1)+1 cycles.
REQ-013 sel SHALL equal ch in SETTLE and CAPTURE, 0 in IDLE and DONE.
REQ-014 start while busy SHALL be ignored; no queued request.
REQ-015 abort=1 in SETTLE, CAPTURE or DONE -> IDLE next cycle; no scan_done, output values and alarm counters unchanged; abort has priority over DONE's updates and over cont.
REQ-016 Alarm counters: 3-bit mq_cnt, w_cnt; at DONE, condition true -> saturating increment to PERSIST, false -> clear to 0.
REQ-017 mqled = (mq_cnt == PERSIST); waterled = (w_cnt == PERSIST); both registered; deassert at the first non-exceeding scan.
REQ-018 Comparisons SHALL be 4-bit unsigned on the values transferred in that DONE.
REQ-019 Output values SHALL only change at DONE; intermediate captures never visible on mq_val/water_val/temp_val.

Reset
REQ-020 rst_n=0 SHALL immediately force IDLE, ch=0, counters 0, sel=0, busy=0, scan_done=0, mq_val=0, water_val=0, temp_val=0, mqled=0, waterled=0, regardless of state.
REQ-021 After rst_n deasserts, the first start SHALL be sampled no earlier than the first rising edge with rst_n=1.

Verification
REQ-022 Defaults, mq7in=2, waterLevel=7, tempin=1, start pulse at edge 0 -> scan_done at edge 16 with mq_val=2, water_val=7, temp_val=1, mqled=0, waterled=0.
REQ-023 cont=1, mq7in=3 held -> scan_done every 16 cycles; mqled rises with the 3rd scan_done, stays high; mq7in=0 -> mqled low at the next scan_done.
REQ-024 waterLevel=5 then 6: 5 never raises waterled; 6 raises it on the 3rd consecutive scan; 6,6,5,6 sequence -> waterled stays 0.
REQ-025 Inputs change during SETTLE of another channel -> only the value present in that channel's CAPTURE cycle appears; sel steps 0,1,2.
REQ-026 abort during ch=1 SETTLE of 2nd scan -> IDLE next cycle, no scan_done, outputs keep 1st-scan values; start during busy ignored.
REQ-027 rst_n low mid-CAPTURE with mqled=1 -> all outputs 0 immediately; next start yields a normal scan at edge 16.
